// File: rtl/bist_sequencer.sv
// ---------------------------------------------------------------------------
// bist_sequencer
//   Sequences one logic-BIST session: clear the pattern generator and
//   compactor, run NUM_PATTERNS stimulus cycles, capture the compactor
//   signature, then report pass/fail against GOLDEN_SIG.
//
// Parameters
//   NUM_PATTERNS  RUN cycles per session (1..255)
//   CLEAR_CYCLES  cycles bist_clear is held (1..15)
//   GOLDEN_SIG    expected 4-bit signature
//
// Ports
//   clock           in   single clock, rising edge
//   reset           in   synchronous, active-low
//   start           in   session request, honoured only in IDLE
//   abort           in   cancel the session (ignored in IDLE start and REPORT)
//   misr_sig[3:0]   in   compactor signature, sampled in CAPTURE
//   bist_clear      out  clear to pattern generator / compactor
//   testmode        out  selects BIST stimulus into the CUT
//   busy            out  high whenever not IDLE
//   done            out  one-cycle pulse while in REPORT
//   pass            out  last completed session matched GOLDEN_SIG
//   fault_detected  out  last completed session mismatched
//   signature[3:0]  out  signature of the last completed session
//   session_count   out  completed sessions, saturating at 255
// ---------------------------------------------------------------------------
module bist_sequencer #(
    parameter int unsigned NUM_PATTERNS = 7,
    parameter int unsigned CLEAR_CYCLES = 2,
    parameter logic [3:0]  GOLDEN_SIG   = 4'b0011
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] misr_sig,
    output logic       bist_clear,
    output logic       testmode,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fault_detected,
    output logic [3:0] signature,
    output logic [7:0] session_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_CAPTURE = 3'd3,
        S_REPORT  = 3'd4
    } state_e;

    localparam logic [7:0] CLR_LAST = 8'(CLEAR_CYCLES - 1);
    localparam logic [7:0] RUN_LAST = 8'(NUM_PATTERNS - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic       clear_q, clear_d;
    logic       tm_q, tm_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic       fault_q, fault_d;
    logic [3:0] sig_q, sig_d;
    logic [7:0] sess_q, sess_d;

    // result registers load only on the CAPTURE->REPORT transition, so an
    // abort in CAPTURE leaves the previous result untouched
    logic       load_result;

    // ------------------------------------------------------------------
    // next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                // start together with abort is treated as no request
                if (start && !abort) begin
                    state_d = S_CLEAR;
                    cnt_d   = 8'd0;
                end
            end
            S_CLEAR: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == CLR_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == RUN_LAST) begin
                    state_d = S_CAPTURE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            S_CAPTURE: begin
                state_d = abort ? S_IDLE : S_REPORT;
                cnt_d   = 8'd0;
            end
            S_REPORT: begin
                // abort is deliberately not looked at: the result completes
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // output decode from the next state, registered so the outputs line up
    // with the state they describe and come straight from flops
    // ------------------------------------------------------------------
    always_comb begin
        clear_d     = (state_d == S_CLEAR);
        tm_d        = (state_d == S_CLEAR) || (state_d == S_RUN) ||
                      (state_d == S_CAPTURE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_REPORT);
        load_result = (state_q == S_CAPTURE) && (state_d == S_REPORT);

        pass_d  = pass_q;
        fault_d = fault_q;
        sig_d   = sig_q;
        sess_d  = sess_q;
        if (load_result) begin
            pass_d  = (misr_sig == GOLDEN_SIG);
            fault_d = (misr_sig != GOLDEN_SIG);
            sig_d   = misr_sig;
            sess_d  = (sess_q == 8'hFF) ? sess_q : sess_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // state and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            clear_q <= 1'b0;
            tm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fault_q <= 1'b0;
            sig_q   <= 4'b0000;
            sess_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clear_q <= clear_d;
            tm_q    <= tm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fault_q <= fault_d;
            sig_q   <= sig_d;
            sess_q  <= sess_d;
        end
    end

    assign bist_clear     = clear_q;
    assign testmode       = tm_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fault_detected = fault_q;
    assign signature      = sig_q;
    assign session_count  = sess_q;

endmodule

// File: tb/tb_bist_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bist_sequencer
//   Scenario tasks drive bist_sequencer and compare against a session-level
//   model: a session started in cycle 0 occupies CLEAR in cycles 1..CC,
//   RUN in the next NP cycles, CAPTURE, then REPORT (done) in cycle CC+NP+2.
//   Completed sessions update the expected result registers.
// ---------------------------------------------------------------------------
module tb_bist_sequencer;
    localparam int         CC   = 2;
    localparam int         NP   = 7;
    localparam int         LAT  = CC + NP + 2;
    localparam logic [3:0] GOLD = 4'b0011;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] misr_sig = 4'b0000;
    logic       bist_clear, testmode, busy, done, pass, fault_detected;
    logic [3:0] signature;
    logic [7:0] session_count;

    int total = 0;
    int bad   = 0;

    // session-level reference state
    logic       exp_pass  = 1'b0;
    logic       exp_fault = 1'b0;
    logic [3:0] exp_sig   = 4'b0000;
    int         exp_cnt   = 0;

    always #5 clock = ~clock;

    bist_sequencer #(
        .NUM_PATTERNS(NP),
        .CLEAR_CYCLES(CC),
        .GOLDEN_SIG  (GOLD)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .misr_sig      (misr_sig),
        .bist_clear    (bist_clear),
        .testmode      (testmode),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fault_detected(fault_detected),
        .signature     (signature),
        .session_count (session_count)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model: record a completed session
    task automatic model_complete(input logic [3:0] sig);
        exp_pass  = (sig == GOLD);
        exp_fault = (sig != GOLD);
        exp_sig   = sig;
        exp_cnt   = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    endtask

    // Drives one stimulus window of ncyc cycles. Bit k of a mask gives the
    // input value during cycle k (cycle 0 = the cycle start is first high).
    // Returns per-window observations; no checking here.
    task automatic do_session(input logic [3:0] sig, input logic [31:0] smask,
                              input logic [31:0] amask, input logic [31:0] rmask,
                              input int ncyc, output int done_cnt, output int done_at,
                              output int clr_cnt, output int tm_cnt, output int busy_cnt);
        done_cnt = 0; done_at = -1; clr_cnt = 0; tm_cnt = 0; busy_cnt = 0;
        misr_sig = sig;
        start    = smask[0];
        abort    = amask[0];
        reset    = ~rmask[0];
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clock); #1;
            if (done === 1'b1) begin done_cnt++; done_at = k; end
            if (bist_clear === 1'b1) clr_cnt++;
            if (testmode === 1'b1)   tm_cnt++;
            if (busy === 1'b1)       busy_cnt++;
            if (k < 32) begin
                start = smask[k];
                abort = amask[k];
                reset = ~rmask[k];
            end
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; abort = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        start = 1'b0;
        total++;
        if ({bist_clear, testmode, busy, done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {bist_clear, testmode, busy, done});
        end
        total++;
        if ({pass, fault_detected, signature, session_count} !== 14'd0) begin
            bad++;
            $display("FAIL reset_result: got pass=%b fault=%b sig=%b cnt=%0d want all 0",
                     pass, fault_detected, signature, session_count);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_pass();
        int dc, da, cc, tc, bc;
        do_session(GOLD, 32'h1, 32'h0, 32'h0, LAT + 1, dc, da, cc, tc, bc);
        model_complete(GOLD);
        total++;
        if (dc !== 1 || da !== LAT) begin
            bad++;
            $display("FAIL pass_latency: done_cnt=%0d done_at=%0d want 1 at %0d", dc, da, LAT);
        end
        total++;
        if (cc !== CC || tc !== LAT - 1 || bc !== LAT) begin
            bad++;
            $display("FAIL pass_timeline: clear=%0d tm=%0d busy=%0d want %0d %0d %0d",
                     cc, tc, bc, CC, LAT - 1, LAT);
        end
        total++;
        if ({pass, fault_detected, signature, session_count} !== {2'b10, 4'b0011, 8'd1}) begin
            bad++;
            $display("FAIL pass_result: pass=%b fault=%b sig=%b cnt=%0d want 1 0 0011 1",
                     pass, fault_detected, signature, session_count);
        end
    endtask

    task automatic test_fail_hold();
        int dc, da, cc, tc, bc;
        int hold_bad;
        do_session(4'b0101, 32'h1, 32'h0, 32'h0, LAT + 1, dc, da, cc, tc, bc);
        model_complete(4'b0101);
        total++;
        if (dc !== 1 || da !== LAT) begin
            bad++;
            $display("FAIL fail_latency: done_cnt=%0d done_at=%0d want 1 at %0d", dc, da, LAT);
        end
        total++;
        if ({pass, fault_detected, signature, session_count} !== {2'b01, 4'b0101, 8'd2}) begin
            bad++;
            $display("FAIL fail_result: pass=%b fault=%b sig=%b cnt=%0d want 0 1 0101 2",
                     pass, fault_detected, signature, session_count);
        end
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            misr_sig = 4'($urandom);
            @(posedge clock); #1;
            total++;
            if ({done, busy, pass, fault_detected, signature, session_count} !==
                {2'b00, exp_pass, exp_fault, exp_sig, 8'(exp_cnt)}) begin
                bad++; hold_bad++;
                if (hold_bad < 4)
                    $display("FAIL idle_hold[%0d]: done=%b busy=%b pass=%b fault=%b sig=%b cnt=%0d",
                             i, done, busy, pass, fault_detected, signature, session_count);
            end
        end
    endtask

    task automatic test_abort();
        int dc, da, cc, tc, bc;
        // abort in the third RUN cycle
        do_session(GOLD, 32'h1, 32'h1 << (CC + 3), 32'h0, LAT + 1, dc, da, cc, tc, bc);
        total++;
        if (dc !== 0 || bc !== CC + 3 || tc !== CC + 3) begin
            bad++;
            $display("FAIL abort_run: done_cnt=%0d busy=%0d tm=%0d want 0 %0d %0d",
                     dc, bc, tc, CC + 3, CC + 3);
        end
        total++;
        if ({pass, fault_detected, signature, session_count} !==
            {exp_pass, exp_fault, exp_sig, 8'(exp_cnt)}) begin
            bad++;
            $display("FAIL abort_run_result: pass=%b fault=%b sig=%b cnt=%0d", pass,
                     fault_detected, signature, session_count);
        end
        // abort in CAPTURE with a signature that would otherwise change things
        do_session(GOLD, 32'h1, 32'h1 << (LAT - 1), 32'h0, LAT + 1, dc, da, cc, tc, bc);
        total++;
        if (dc !== 0 || bc !== LAT - 1 || tc !== LAT - 1) begin
            bad++;
            $display("FAIL abort_capture: done_cnt=%0d busy=%0d tm=%0d want 0 %0d %0d",
                     dc, bc, tc, LAT - 1, LAT - 1);
        end
        total++;
        if ({pass, fault_detected, signature, session_count} !==
            {exp_pass, exp_fault, exp_sig, 8'(exp_cnt)}) begin
            bad++;
            $display("FAIL abort_capture_result: pass=%b fault=%b sig=%b cnt=%0d", pass,
                     fault_detected, signature, session_count);
        end
        // a fresh session completes normally
        do_session(GOLD, 32'h1, 32'h0, 32'h0, LAT + 1, dc, da, cc, tc, bc);
        model_complete(GOLD);
        total++;
        if (dc !== 1 || da !== LAT ||
            {pass, fault_detected, signature, session_count} !==
            {exp_pass, exp_fault, exp_sig, 8'(exp_cnt)}) begin
            bad++;
            $display("FAIL abort_recover: done_at=%0d pass=%b sig=%b cnt=%0d want %0d 1 0011 %0d",
                     da, pass, signature, session_count, LAT, exp_cnt);
        end
    endtask

    task automatic test_ignore_start();
        int dc, da, cc, tc, bc;
        logic [31:0] sm;
        // re-pulse start in CLEAR, RUN and REPORT; abort in REPORT
        sm = 32'h1 | (32'h1 << 1) | (32'h1 << (CC + 2)) | (32'h1 << LAT);
        do_session(4'b1001, sm, 32'h1 << LAT, 32'h0, LAT + 3, dc, da, cc, tc, bc);
        model_complete(4'b1001);
        total++;
        if (dc !== 1 || da !== LAT || bc !== LAT) begin
            bad++;
            $display("FAIL ignore_start: done_cnt=%0d done_at=%0d busy=%0d want 1 %0d %0d",
                     dc, da, bc, LAT, LAT);
        end
        total++;
        if ({pass, fault_detected, signature, session_count} !==
            {exp_pass, exp_fault, exp_sig, 8'(exp_cnt)}) begin
            bad++;
            $display("FAIL abort_in_report: pass=%b fault=%b sig=%b cnt=%0d want cnt=%0d",
                     pass, fault_detected, signature, session_count, exp_cnt);
        end
        // start and abort together in IDLE
        do_session(GOLD, 32'h1, 32'h1, 32'h0, 4, dc, da, cc, tc, bc);
        total++;
        if (bc !== 0 || dc !== 0) begin
            bad++;
            $display("FAIL start_abort_idle: busy cycles=%0d done=%0d want 0 0", bc, dc);
        end
    endtask

    task automatic test_random();
        int dc, da, cc, tc, bc;
        int a, e_dc, e_bc, e_cc, e_tc;
        logic [3:0] sig;
        logic [31:0] am;
        for (int i = 0; i < 30; i++) begin
            sig = ($urandom_range(0, 1) == 1) ? GOLD : 4'($urandom);
            a   = $urandom_range(0, LAT + 3);
            am  = (a <= LAT) ? (32'h1 << a) : 32'h0;
            do_session(sig, 32'h1, am, 32'h0, LAT + 1, dc, da, cc, tc, bc);
            if (a == 0) begin
                e_dc = 0; e_bc = 0; e_cc = 0; e_tc = 0;
            end else if (a <= LAT - 1) begin
                e_dc = 0; e_bc = a; e_cc = (a < CC) ? a : CC; e_tc = a;
            end else begin
                e_dc = 1; e_bc = LAT; e_cc = CC; e_tc = LAT - 1;
                model_complete(sig);
            end
            total++;
            if (dc !== e_dc || bc !== e_bc || cc !== e_cc || tc !== e_tc) begin
                bad++;
                $display("FAIL rand_timeline[%0d] abort@%0d: done=%0d busy=%0d clr=%0d tm=%0d want %0d %0d %0d %0d",
                         i, a, dc, bc, cc, tc, e_dc, e_bc, e_cc, e_tc);
            end
            total++;
            if ({pass, fault_detected, signature, session_count} !==
                {exp_pass, exp_fault, exp_sig, 8'(exp_cnt)}) begin
                bad++;
                $display("FAIL rand_result[%0d]: pass=%b fault=%b sig=%b cnt=%0d want %b %b %b %0d",
                         i, pass, fault_detected, signature, session_count,
                         exp_pass, exp_fault, exp_sig, exp_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int dc, da, cc, tc, bc;
        // reset low during the fourth RUN cycle
        do_session(GOLD, 32'h1, 32'h0, 32'h1 << (CC + 4), CC + 5, dc, da, cc, tc, bc);
        exp_pass = 1'b0; exp_fault = 1'b0; exp_sig = 4'b0000; exp_cnt = 0;
        total++;
        if ({bist_clear, testmode, busy, done, pass, fault_detected, signature, session_count} !== 18'd0) begin
            bad++;
            $display("FAIL reset_mid: clr=%b tm=%b busy=%b done=%b pass=%b fault=%b sig=%b cnt=%0d want all 0",
                     bist_clear, testmode, busy, done, pass, fault_detected, signature, session_count);
        end
        total++;
        if (dc !== 0 || bc !== CC + 4) begin
            bad++;
            $display("FAIL reset_mid_timeline: done=%0d busy=%0d want 0 %0d", dc, bc, CC + 4);
        end
    endtask

    task automatic test_back_to_back();
        int dc, da, cc, tc, bc;
        int sat_bad;
        sat_bad = 0;
        for (int i = 1; i <= 260; i++) begin
            do_session(GOLD, 32'h1, 32'h0, 32'h0, LAT + 1, dc, da, cc, tc, bc);
            model_complete(GOLD);
            total++;
            if (cc !== CC || dc !== 1 || da !== LAT || int'(session_count) !== exp_cnt) begin
                bad++; sat_bad++;
                if (sat_bad < 4)
                    $display("FAIL b2b[%0d]: clear=%0d done=%0d@%0d cnt=%0d want %0d 1@%0d %0d",
                             i, cc, dc, da, session_count, CC, LAT, exp_cnt);
            end
        end
        repeat (3) @(posedge clock);
        #1;
        total++;
        if (session_count !== 8'd255) begin
            bad++;
            $display("FAIL saturate: cnt=%0d want 255", session_count);
        end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_hold();
        test_abort();
        test_ignore_start();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bist_sequencer.md
BIST_SEQUENCER -- requirements
Module: bist_sequencer

Interface
REQ-001 SHALL have parameter NUM_PATTERNS, default 7, giving the number of RUN cycles per session (range 1..255).
REQ-002 SHALL have parameter CLEAR_CYCLES, default 2, giving the number of cycles bist_clear is held (range 1..15).
REQ-003 SHALL have parameter GOLDEN_SIG, default 4'b0011, giving the expected 4-bit signature.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: session request, sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1 bit: cancels the session in progress.
REQ-008 SHALL have port misr_sig, input, 4 bits: signature from the downstream compactor.
REQ-009 SHALL have port bist_clear, output, 1 bit: active-high clear to the pattern generator and compactor.
REQ-010 SHALL have port testmode, output, 1 bit: selects pattern-generator stimulus into the CUT.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a result is valid.
REQ-013 SHALL have port pass, output, 1 bit: result of the last completed session.
REQ-014 SHALL have port fault_detected, output, 1 bit: the inverse of pass after a completed session.
REQ-015 SHALL have port signature, output, 4 bits: misr_sig as captured in the last completed session.
REQ-016 SHALL have port session_count, output, 8 bits: number of completed sessions, saturating.

Function
REQ-017 SHALL implement the FSM states IDLE, CLEAR, RUN, CAPTURE and REPORT, with registered outputs decoded from the state.
REQ-018 In IDLE: start=1 and abort=0 SHALL go to CLEAR next cycle and load the cycle counter with 0.
REQ-019 In CLEAR: bist_clear=1 and testmode=1; after exactly CLEAR_CYCLES cycles SHALL go to RUN with the counter reset to 0.
REQ-020 In RUN: bist_clear=0 and testmode=1; the counter increments each cycle; after exactly NUM_PATTERNS cycles SHALL go to CAPTURE.
REQ-021 In CAPTURE (1 cycle, testmode=1): signature<=misr_sig and a pass flag computed as (misr_sig==GOLDEN_SIG) SHALL be latched internally.
REQ-022 In REPORT (1 cycle, testmode=0): done=1, pass and fault_detected update, session_count increments, then SHALL go to IDLE.
REQ-023 From start acceptance to the done pulse SHALL take exactly CLEAR_CYCLES+NUM_PATTERNS+2 cycles.
REQ-024 pass, fault_detected and signature SHALL hold their values until the next REPORT.
REQ-025 start asserted while busy=1 SHALL be ignored and not queued.
REQ-026 abort=1 in CLEAR, RUN or CAPTURE SHALL go to IDLE next cycle with no done pulse, no change to pass, fault_detected, signature or session_count, and testmode=0 next cycle.
REQ-027 abort=1 in REPORT SHALL be ignored; the result completes.
REQ-028 start=1 and abort=1 together in IDLE SHALL leave the FSM in IDLE.
REQ-029 session_count SHALL saturate at 255 and not wrap.
REQ-030 Back-to-back operation: start=1 in the cycle after done SHALL be accepted, since the FSM is then in IDLE.

Reset
REQ-031 reset=0 at a clock edge SHALL force IDLE with bist_clear=0, testmode=0, busy=0, done=0, pass=0, fault_detected=0, signature=4'b0000, session_count=0, and counter=0.
REQ-032 Reset SHALL take priority over start and abort, and reset mid-session SHALL discard the session with no done pulse.
REQ-033 Between reset and the first REPORT, pass=0 and fault_detected=0 SHALL indicate "no result".

Verification
REQ-034 Defaults; start pulse; misr_sig=4'b0011 at CAPTURE -> done exactly 11 cycles after start, pass=1, fault_detected=0, signature=4'b0011, session_count=1.
REQ-035 Same stimulus with misr_sig=4'b0101 -> pass=0, fault_detected=1, signature=4'b0101; values held for 20 idle cycles.
REQ-036 abort in RUN cycle 3 -> IDLE next cycle, no done pulse, previous results unchanged; a new start then completes normally.
REQ-037 start re-pulsed in CLEAR and RUN -> ignored, exactly one done; start+abort together in IDLE -> busy stays 0.
REQ-038 reset=0 in RUN cycle 4 -> all outputs at reset values next cycle, session_count=0.
REQ-039 260 back-to-back passing sessions -> session_count=255 and held there, bist_clear high exactly CLEAR_CYCLES cycles per session.
